img_window_fetch: RTL and testbench



---
 rtl/img_window_fetch.sv | 143 ++++++++++++++
 tb/tb_img_window_fetch.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/img_window_fetch.sv
// Walks a stored image and assembles KxK convolution windows from a one-cycle-latency
// synchronous memory. Windows are presented in raster order over a valid/ready handshake.
module img_window_fetch #(
  parameter int unsigned DW        = 16,
  parameter int unsigned AW        = 16,
  parameter int unsigned IMG_W     = 32,
  parameter int unsigned IMG_H     = 32,
  parameter int unsigned K         = 5,
  parameter int unsigned BASE_ADDR = 50704
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [AW-1:0]     mem_addr,
  input  logic [DW-1:0]     mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [K*K*DW-1:0] window_data,
  output logic [4:0]        win_row,
  output logic [4:0]        win_col,
  output logic              done
);

  localparam int unsigned NK = K * K;
  localparam int unsigned KW = $clog2(NK);
  localparam int unsigned RW = $clog2(K);

  localparam logic [KW-1:0] K_LAST   = KW'(NK - 1);
  localparam logic [RW-1:0] KC_LAST  = RW'(K - 1);
  localparam logic [4:0]    COL_LAST = 5'(IMG_W - K);
  localparam logic [4:0]    ROW_LAST = 5'(IMG_H - K);

  typedef enum logic [2:0] {IDLE, FETCH, LAST, PRESENT, DONE} state_t;

  state_t        state;
  logic [KW-1:0] k;
  logic [RW-1:0] kr, kc;
  logic [RW-1:0] nkr, nkc;
  logic [4:0]    nrow, ncol;
  logic          last_win;
  logic          cap_valid;
  logic [KW-1:0] cap_slot;

  function automatic logic [AW-1:0] addr_of(input logic [4:0] row, input logic [4:0] col,
                                            input logic [RW-1:0] r, input logic [RW-1:0] c);
    logic [31:0] a;
    a = 32'(BASE_ADDR) + (32'(row) + 32'(r)) * 32'(IMG_W) + 32'(col) + 32'(c);
    return a[AW-1:0];
  endfunction

  always_comb begin
    nkr = kr;
    nkc = kc + 1'b1;
    if (kc == KC_LAST) begin
      nkc = '0;
      nkr = kr + 1'b1;
    end
    nrow     = win_row;
    ncol     = win_col + 1'b1;
    last_win = 1'b0;
    if (win_col >= COL_LAST) begin
      ncol = '0;
      nrow = win_row + 1'b1;
      last_win = (win_row >= ROW_LAST);
    end
  end

  // Read data trails the address by one cycle, so the issued slot index is
  // carried alongside in cap_slot and written on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      k           <= '0;
      kr          <= '0;
      kc          <= '0;
      cap_valid   <= 1'b0;
      cap_slot    <= '0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      out_valid   <= 1'b0;
      window_data <= '0;
      win_row     <= '0;
      win_col     <= '0;
      done        <= 1'b0;
    end else begin
      cap_valid <= 1'b0;
      if (cap_valid) window_data[32'(cap_slot)*DW +: DW] <= mem_rdata;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            win_row   <= '0;
            win_col   <= '0;
            k         <= '0;
            kr        <= '0;
            kc        <= '0;
            mem_addr  <= AW'(BASE_ADDR);
            mem_rd_en <= 1'b1;
            done      <= 1'b0;
            state     <= FETCH;
          end
        end
        FETCH: begin
          cap_valid <= 1'b1;
          cap_slot  <= k;
          if (k == K_LAST) begin
            mem_rd_en <= 1'b0;
            state     <= LAST;
          end else begin
            k        <= k + 1'b1;
            kr       <= nkr;
            kc       <= nkc;
            mem_addr <= addr_of(win_row, win_col, nkr, nkc);
          end
        end
        LAST: begin
          out_valid <= 1'b1;
          state     <= PRESENT;
        end
        PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_win) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              win_row   <= nrow;
              win_col   <= ncol;
              k         <= '0;
              kr        <= '0;
              kc        <= '0;
              mem_addr  <= addr_of(nrow, ncol, '0, '0);
              mem_rd_en <= 1'b1;
              state     <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_img_window_fetch.sv
// Scoreboard bench for img_window_fetch: expected windows are queued on start and
// popped on each accepted handshake; read addresses are checked against the same model.
module tb_img_window_fetch;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 16;
  localparam int unsigned IMG_W = 32;
  localparam int unsigned IMG_H = 32;
  localparam int unsigned K     = 5;
  localparam int unsigned BASE  = 50704;
  localparam int unsigned WW    = K * K * DW;
  localparam int unsigned NWIN  = (IMG_W - K + 1) * (IMG_H - K + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          out_valid;
  logic          done;
  logic [WW-1:0] window_data;
  logic [4:0]    win_row, win_col;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  typedef struct {
    int unsigned row;
    int unsigned col;
  } win_t;

  win_t        exp_q[$];
  win_t        cur;
  int unsigned rd_idx = 0;
  int unsigned acc_cnt = 0;
  logic [WW-1:0] snap;

  img_window_fetch #(
    .DW(DW), .AW(AW), .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .window_data(window_data),
    .win_row(win_row), .win_col(win_col), .done(done)
  );

  always #5 clk = ~clk;

  // Memory holds mem[BASE+i] = i for the 1024 image words.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      if (32'(mem_addr) >= BASE && 32'(mem_addr) < BASE + 1024)
        mem_rdata <= DW'(32'(mem_addr) - BASE);
      else
        mem_rdata <= 16'hdead;
    end
  end

  task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WW-1:0] exp_window(input int unsigned row, input int unsigned col);
    logic [WW-1:0] w;
    w = '0;
    for (int unsigned r = 0; r < K; r++)
      for (int unsigned c = 0; c < K; c++)
        w[(r*K+c)*DW +: DW] = DW'((row + r) * IMG_W + col + c);
    return w;
  endfunction

  function automatic logic [AW-1:0] exp_addr(input int unsigned row, input int unsigned col,
                                             input int unsigned j);
    return AW'(BASE + (row + j / K) * IMG_W + col + j % K);
  endfunction

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rd_in_reset", WW'(mem_rd_en), '0);
      exp_q.delete();
      rd_idx  = 0;
      acc_cnt = 0;
    end else begin
      if (start) begin
        exp_q.delete();
        for (int unsigned r = 0; r <= IMG_H - K; r++)
          for (int unsigned c = 0; c <= IMG_W - K; c++)
            exp_q.push_back('{row: r, col: c});
        rd_idx  = 0;
        acc_cnt = 0;
      end
      if (mem_rd_en) begin
        check("rd_expected", WW'(rd_idx < K*K && exp_q.size() != 0), WW'(1));
        if (rd_idx < K*K && exp_q.size() != 0)
          check("rd_addr", WW'(mem_addr), WW'(exp_addr(exp_q[0].row, exp_q[0].col, rd_idx)));
        rd_idx++;
      end
      if (out_valid && out_ready) begin
        acc_cnt++;
        check("fetch_reads", WW'(rd_idx), WW'(K*K));
        rd_idx = 0;
        check("acc_has_exp", WW'(exp_q.size() != 0), WW'(1));
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          check("win_row", WW'(win_row), WW'(cur.row));
          check("win_col", WW'(win_col), WW'(cur.col));
          check("window", window_data, exp_window(cur.row, cur.col));
        end
        if (acc_cnt == 1) begin
          check("w1_pos", WW'({win_row, win_col}), '0);
          check("w1_e0", WW'(window_data[0 +: DW]), WW'(0));
        end
        if (acc_cnt == 28) begin
          check("w28_col", WW'(win_col), WW'(27));
          check("w28_e0", WW'(window_data[0 +: DW]), WW'(27));
        end
        if (acc_cnt == 29) begin
          check("w29_row", WW'(win_row), WW'(1));
          check("w29_col", WW'(win_col), WW'(0));
          check("w29_e0", WW'(window_data[0 +: DW]), WW'(32));
          check("w29_e24", WW'(window_data[24*DW +: DW]), WW'(164));
        end
        if (acc_cnt == NWIN) begin
          check("wlast_e0", WW'(window_data[0 +: DW]), WW'(891));
          check("wlast_e24", WW'(window_data[24*DW +: DW]), WW'(1023));
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, WW'(out_valid), '0);
    check({tag, "_done"}, WW'(done), '0);
    check({tag, "_rd_en"}, WW'(mem_rd_en), '0);
    check({tag, "_addr"}, WW'(mem_addr), '0);
    check({tag, "_data"}, window_data, '0);
    check({tag, "_row"}, WW'(win_row), '0);
    check({tag, "_col"}, WW'(win_col), '0);
  endtask

  task automatic wait_acc(input int unsigned n, input int unsigned budget);
    int unsigned t;
    t = 0;
    while (acc_cnt < n && t < budget) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("wait_acc", WW'(acc_cnt >= n), WW'(1));
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  initial begin
    // Reset held while start toggles.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1 start = ~start;
    end
    start = 1'b0;
    @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk); #1 rst_n = 1'b1;

    // First window latency and contents, consumer not ready.
    pulse_start();
    repeat (25) @(posedge clk);
    @(negedge clk);
    check("valid_e25", WW'(out_valid), '0);
    @(posedge clk);
    @(negedge clk);
    check("valid_e26", WW'(out_valid), WW'(1));
    check("w1_e0c", WW'(window_data[0*DW +: DW]), WW'(0));
    check("w1_e4", WW'(window_data[4*DW +: DW]), WW'(4));
    check("w1_e5", WW'(window_data[5*DW +: DW]), WW'(32));
    check("w1_e24", WW'(window_data[24*DW +: DW]), WW'(132));
    snap = window_data;

    // Backpressure, then a single-cycle ready.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", WW'(out_valid), WW'(1));
      check("bp_data", window_data, snap);
      check("bp_rd_en", WW'(mem_rd_en), '0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    check("one_hs_col", WW'(win_col), WW'(1));
    check("one_hs_cnt", WW'(acc_cnt), WW'(1));
    repeat (40) @(negedge clk);
    check("hold_cnt", WW'(acc_cnt), WW'(1));
    check("hold_valid", WW'(out_valid), WW'(1));

    // Full pass to completion.
    @(posedge clk); #1 out_ready = 1'b1;
    wait_acc(NWIN, NWIN * 30);
    @(negedge clk);
    check("done_set", WW'(done), WW'(1));
    check("done_valid", WW'(out_valid), '0);
    check("q_empty", WW'(exp_q.size()), '0);

    // Restart from DONE, then reset during k=12 of window 3.
    pulse_start();
    @(negedge clk);
    check("done_clr", WW'(done), '0);
    wait_acc(2, 200);
    for (int t = 0; t < 100 && rd_idx != 13; t++) begin
      @(negedge clk);
      #1;
    end
    check("midk12_rd", WW'(mem_rd_en), WW'(1));
    check("midk12_addr", WW'(mem_addr), WW'(50772));
    check("midk12_cnt", WW'(acc_cnt), WW'(2));
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid");
    @(posedge clk); #1 rst_n = 1'b1;
    pulse_start();
    wait_acc(1, 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
